// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receiver slice.
//   rx_state_t  : receiver FSM state encoding
//   PARITY_*    : parity-mode constants for the PARITY parameter
//   cnt_width() : counter width needed to hold 0..max_count-1
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Width of a counter that counts 0..max_count-1; never narrower than 1 bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Oversample tick generator: pulses tick for one cycle every DIV clk cycles.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   restart : forces the divider back to 0 so the first tick lands DIV cycles later
//   tick    : one-cycle oversample strobe
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parameterised UART receiver with oversampled mid-bit sampling, optional
// parity, 1 or 2 checked stop bits, break recovery and a valid/ready output.
// Ports:
//   clk        : sole clock
//   rst        : synchronous active-high reset
//   rxd        : asynchronous serial line, idle high, LSB first
//   rx_ready   : consumer accepts the held word
//   rx_data    : received word (keeps its value after the handshake)
//   rx_valid   : rx_data and flags valid, held until rx_valid && rx_ready
//   parity_err : parity mismatch on the held word
//   frame_err  : a stop bit sampled low on the held word
//   overrun    : one-cycle pulse when a completed frame is dropped
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DIV       = 27,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int               OVS_W     = cnt_width(OVS);
  localparam int               BIT_W     = cnt_width(DATA_BITS);
  localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID   = OVS_W'(OVS / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 tick;
  logic                 restart;
  logic                 bit_sample;
  logic                 stop_bad_now;
  rx_state_t            state;
  logic [OVS_W-1:0]     ovs_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 stop_bad;

  // Two-flop synchronizer; resets to the idle-high level so reset never
  // looks like a start bit.
  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxs = sync_q[1];

  // The divider is realigned to the falling edge of the start bit so that
  // samples land at the middle of each bit.
  assign restart = (state == ST_IDLE) && !rxs;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // Full-bit sample point: OVS ticks after the previous sample.
  assign bit_sample   = tick && (ovs_cnt == OVS_LAST);
  assign stop_bad_now = stop_bad || !rxs;

  // NOTE: the shift register is deliberately left without reset: every bit is
  // overwritten by the data samples before the word can be loaded to rx_data.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && bit_sample) begin
      shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ovs_cnt    <= '0;
      bit_cnt    <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Handshake clears the word; a frame completing in the same cycle
      // overrides this below, so the new word loads without an overrun.
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          ovs_cnt  <= '0;
          bit_cnt  <= '0;
          par_bad  <= 1'b0;
          stop_bad <= 1'b0;
          if (!rxs) begin
            state <= ST_START;
          end
        end

        // Confirm the start bit at its midpoint; a high sample is a glitch.
        ST_START: begin
          if (tick) begin
            if (ovs_cnt == OVS_MID) begin
              ovs_cnt <= '0;
              state   <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_sample) begin
              ovs_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        // XOR of data and parity bit is 0 for even mode, 1 for odd mode.
        ST_PARITY: begin
          if (tick) begin
            if (bit_sample) begin
              ovs_cnt <= '0;
              par_bad <= (^shreg ^ rxs) ^ (PARITY == PARITY_ODD);
              state   <= ST_STOP;
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (bit_sample) begin
              ovs_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt <= '0;
                state   <= stop_bad_now ? ST_WAIT_IDLE : ST_IDLE;
                if (!rx_valid || rx_ready) begin
                  rx_data    <= shreg;
                  rx_valid   <= 1'b1;
                  parity_err <= par_bad;
                  frame_err  <= stop_bad_now;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                stop_bad <= stop_bad_now;
              end
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        // Break recovery: wait for OVS consecutive high ticks; any low level
        // restarts the count so a held-low line never re-triggers a frame.
        ST_WAIT_IDLE: begin
          if (!rxs) begin
            ovs_cnt <= '0;
          end else if (tick) begin
            if (ovs_cnt == OVS_LAST) begin
              ovs_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              ovs_cnt <= ovs_cnt + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int DIV     = 27;
  localparam int OVS     = 16;
  localparam int BIT_CLK = DIV * OVS;
  // Edge at which rx_valid is first seen, counted from the edge after which
  // the start bit is driven: 2 synchronizer edges + 1 edge to leave idle,
  // then one tick per DIV cycles; the start is sampled OVS/2 ticks in, each
  // later bit (8 data [+ parity] + 1 stop) OVS ticks apart, and rx_valid is
  // set by the edge that ends the final stop-sample tick cycle.
  localparam int LAT_8N1 = 3 + DIV * (OVS / 2 + OVS * 9);
  localparam int LAT_8E1 = 3 + DIV * (OVS / 2 + OVS * 10);

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd_a, rxd_b;
  logic       rx_ready_a, rx_ready_b;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_perr, a_ferr, a_ovr;
  logic       b_valid, b_perr, b_ferr, b_ovr;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 8N1 receiver
  uart_rx_param #(.DIV(DIV), .OVS(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_ready(rx_ready_a),
    .rx_data(a_data), .rx_valid(a_valid), .parity_err(a_perr),
    .frame_err(a_ferr), .overrun(a_ovr)
  );

  // 8E1 receiver
  uart_rx_param #(.DIV(DIV), .OVS(OVS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_ready(rx_ready_b),
    .rx_data(b_data), .rx_valid(b_valid), .parity_err(b_perr),
    .frame_err(b_ferr), .overrun(b_ovr)
  );

  // ---------------- output monitors (sampled on the falling edge) ----------
  word_t       got_a[$], got_b[$];
  int unsigned rise_a[$], rise_b[$];
  int          valid_cyc_a, ovr_a, ovr_b, inv_viol;
  logic        vld_a_q = 1'b0, vld_b_q = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && !vld_a_q) rise_a.push_back(cyc);
      if (a_valid) valid_cyc_a++;
      if (a_valid && rx_ready_a) got_a.push_back({a_data, a_perr, a_ferr});
      if (a_ovr) ovr_a++;
      if (b_valid && !vld_b_q) rise_b.push_back(cyc);
      if (b_valid && rx_ready_b) got_b.push_back({b_data, b_perr, b_ferr});
      if (b_ovr) ovr_b++;
      if ((!a_valid && (a_perr || a_ferr)) || (!b_valid && (b_perr || b_ferr))) inv_viol++;
    end
    vld_a_q = a_valid;
    vld_b_q = b_valid;
  end

  task automatic mon_clear_a();
    got_a.delete();
    rise_a.delete();
    valid_cyc_a = 0;
    ovr_a = 0;
  endtask

  task automatic mon_clear_b();
    got_b.delete();
    rise_b.delete();
    ovr_b = 0;
  endtask

  // ---------------- reference model ----------------------------------------
  function automatic word_t mk_word(input logic [7:0] d, input logic pe, input logic fe);
    return {d, pe, fe};
  endfunction

  // Even parity: the XOR of data and parity bit must be 0.
  function automatic logic even_par_err(input logic [7:0] d, input logic p);
    int ones = p;
    for (int i = 0; i < 8; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction

  // ---------------- line driver ---------------------------------------------
  task automatic drive(input bit to_b, input logic v);
    if (to_b) rxd_b = v;
    else      rxd_a = v;
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] data, input bit has_par,
                            input bit par_bit, input bit stop_bit, input int tail_low,
                            output int unsigned start_cyc);
    logic [10:0] bits;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
    n = 9;
    if (has_par) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      drive(to_b, bits[i]);
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    if (tail_low > 0) begin
      drive(to_b, 1'b0);
      repeat (tail_low) @(posedge clk);
      #1;
    end
    drive(to_b, 1'b1);
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_perr, a_ferr, a_ovr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b, expected 0000", {a_valid, a_perr, a_ferr, a_ovr});
    end
    checks++;
    if (a_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_a: got %h, expected 00", a_data);
    end
    checks++;
    if ({b_valid, b_perr, b_ferr, b_ovr, b_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_b: got %h, expected 000", {b_valid, b_perr, b_ferr, b_ovr, b_data});
    end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, b_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got %b, expected 00", {a_valid, b_valid});
    end
  endtask

  task automatic test_frames_a();
    logic [7:0]  vals[3];
    int unsigned st[3];
    vals[0] = 8'hA5;
    vals[1] = 8'($urandom_range(0, 255));
    vals[2] = 8'($urandom_range(0, 255));
    mon_clear_a();
    for (int i = 0; i < 3; i++) send_frame(1'b0, vals[i], 1'b0, 1'b0, 1'b1, 0, st[i]);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 3 || rise_a.size() != 3) begin
      errors++;
      $display("FAIL frames_a_count: got %0d words, expected 3", got_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_a[i] !== mk_word(vals[i], 1'b0, 1'b0)) begin
          errors++;
          $display("FAIL frames_a_word%0d: got %h, expected %h", i, got_a[i], mk_word(vals[i], 1'b0, 1'b0));
        end
        checks++;
        if (rise_a[i] - st[i] != LAT_8N1) begin
          errors++;
          $display("FAIL frames_a_latency%0d: got %0d, expected %0d", i, rise_a[i] - st[i], LAT_8N1);
        end
      end
    end
    checks++;
    if (valid_cyc_a != 3) begin
      errors++;
      $display("FAIL frames_a_valid_pulse: got %0d valid cycles, expected 3", valid_cyc_a);
    end
  endtask

  task automatic test_parity_b();
    logic [7:0]  d[3];
    logic        p[3];
    int unsigned st[3];
    d[0] = 8'h03; p[0] = 1'b1;
    d[1] = 8'h03; p[1] = 1'b0;
    d[2] = 8'($urandom_range(0, 255)); p[2] = 1'($urandom_range(0, 1));
    mon_clear_b();
    for (int i = 0; i < 3; i++) send_frame(1'b1, d[i], 1'b1, p[i], 1'b1, 0, st[i]);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (got_b.size() != 3 || rise_b.size() != 3) begin
      errors++;
      $display("FAIL parity_count: got %0d words, expected 3", got_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_b[i] !== mk_word(d[i], even_par_err(d[i], p[i]), 1'b0)) begin
          errors++;
          $display("FAIL parity_word%0d: got %h, expected %h", i, got_b[i],
                   mk_word(d[i], even_par_err(d[i], p[i]), 1'b0));
        end
      end
      checks++;
      if (rise_b[0] - st[0] != LAT_8E1) begin
        errors++;
        $display("FAIL parity_latency: got %0d, expected %0d", rise_b[0] - st[0], LAT_8E1);
      end
    end
  endtask

  task automatic test_break();
    int unsigned st;
    mon_clear_a();
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2000, st);
    repeat (1000) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 1 || valid_cyc_a != 1) begin
      errors++;
      $display("FAIL break_pulse: got %0d words / %0d valid cycles, expected 1 / 1", got_a.size(), valid_cyc_a);
    end else begin
      checks++;
      if (got_a[0] !== mk_word(8'h00, 1'b0, 1'b1)) begin
        errors++;
        $display("FAIL break_word: got %h, expected %h", got_a[0], mk_word(8'h00, 1'b0, 1'b1));
      end
    end
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 0, st);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 2) begin
      errors++;
      $display("FAIL break_recover_count: got %0d words, expected 2", got_a.size());
    end else if (got_a[1] !== mk_word(8'h55, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL break_recover_word: got %h, expected %h", got_a[1], mk_word(8'h55, 1'b0, 1'b0));
    end
  endtask

  task automatic test_glitch();
    mon_clear_a();
    @(posedge clk);
    #1;
    rxd_a = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rxd_a = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 0 || valid_cyc_a != 0) begin
      errors++;
      $display("FAIL glitch: got %0d words / %0d valid cycles, expected 0 / 0", got_a.size(), valid_cyc_a);
    end
  endtask

  task automatic test_overrun();
    int unsigned st;
    mon_clear_a();
    rx_ready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 0, st);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 0, st);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_data} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL overrun_hold: got %b/%h, expected 1/11", a_valid, a_data);
    end
    checks++;
    if (ovr_a != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulse cycles, expected 1", ovr_a);
    end
    rx_ready_a = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_perr, a_ferr, a_data} !== {3'b000, 8'h11}) begin
      errors++;
      $display("FAIL overrun_release: got %b/%h, expected 000/11", {a_valid, a_perr, a_ferr}, a_data);
    end
    checks++;
    if (got_a.size() != 1) begin
      errors++;
      $display("FAIL overrun_handshakes: got %0d, expected 1", got_a.size());
    end
  endtask

  task automatic test_back_to_back_handshake();
    int unsigned st;
    mon_clear_a();
    rx_ready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 0, st);
    fork
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 0, st);
      begin
        // Raise rx_ready for exactly the cycle in which 0x22 completes.
        @(posedge clk);
        repeat (LAT_8N1 - 1) @(posedge clk);
        #1;
        rx_ready_a = 1'b1;
        @(posedge clk);
        #1;
        rx_ready_a = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({a_valid, a_data} !== {1'b1, 8'h22}) begin
      errors++;
      $display("FAIL collide_load: got %b/%h, expected 1/22", a_valid, a_data);
    end
    checks++;
    if (ovr_a != 0) begin
      errors++;
      $display("FAIL collide_overrun: got %0d pulse cycles, expected 0", ovr_a);
    end
    rx_ready_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 2) begin
      errors++;
      $display("FAIL collide_count: got %0d words, expected 2", got_a.size());
    end else if ({got_a[0].data, got_a[1].data} !== 16'h1122) begin
      errors++;
      $display("FAIL collide_order: got %h %h, expected 11 22", got_a[0].data, got_a[1].data);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned st;
    mon_clear_a();
    rx_ready_a = 1'b0;
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 0, st);
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (a_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precond: got %b, expected 1", a_valid);
    end
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0, st);
      begin
        // Middle of data bit 4 (line bit index 5); held until the frame ends.
        @(posedge clk);
        repeat (5 * BIT_CLK + 200) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_valid, a_perr, a_ferr, a_ovr, a_data} !== 12'h000) begin
          errors++;
          $display("FAIL midreset_outputs: got %h, expected 000", {a_valid, a_perr, a_ferr, a_ovr, a_data});
        end
        repeat (2500) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    rx_ready_a = 1'b1;
    repeat (50) @(posedge clk);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 0, st);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (got_a.size() != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d words, expected 1", got_a.size());
    end else if (got_a[0] !== mk_word(8'hC3, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL midreset_word: got %h, expected %h", got_a[0], mk_word(8'hC3, 1'b0, 1'b0));
    end
  endtask

  task automatic test_flag_invariant();
    checks++;
    if (inv_viol != 0) begin
      errors++;
      $display("FAIL flags_without_valid: got %0d cycles, expected 0", inv_viol);
    end
  endtask

  initial begin
    rst        = 1'b1;
    rxd_a      = 1'b1;
    rxd_b      = 1'b1;
    rx_ready_a = 1'b1;
    rx_ready_b = 1'b1;
    inv_viol   = 0;
    mon_clear_a();
    mon_clear_b();

    test_reset();
    fork
      test_frames_a();
      test_parity_b();
    join
    test_break();
    test_glitch();
    test_overrun();
    test_back_to_back_handshake();
    test_reset_midframe();
    test_flag_invariant();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
